// File: rtl/multi_timer.sv
// Multi-channel compare timer behind a simple req/we register bus.
// A shared prescaler generates ticks that advance each enabled channel's counter toward its compare value.
module multi_timer #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int NumChannels  = 2,
  parameter int PrescWidth   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    data_i,
  output logic [DataWidth-1:0]    data_o,
  output logic                    rvalid_o,
  output logic [NumChannels-1:0]  irq_o,
  output logic                    halt_o
);
  localparam int WordWidth = AddressWidth - 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic enable;
  } ctrl_t;

  logic [WordWidth-1:0]   word;
  logic                   wr, rd;
  logic                   sel_presc, sel_status;
  logic [NumChannels-1:0] sel_ctrl, sel_cmp, sel_cnt;

  logic [PrescWidth-1:0]  presc_q, presc_cnt_q, presc_cnt_d;
  logic                   tick;
  ctrl_t                  ctrl_q [NumChannels];
  ctrl_t                  ctrl_d [NumChannels];
  logic [DataWidth-1:0]   cmp_q  [NumChannels];
  logic [DataWidth-1:0]   cmp_d  [NumChannels];
  logic [DataWidth-1:0]   cnt_q  [NumChannels];
  logic [DataWidth-1:0]   cnt_d  [NumChannels];
  logic [NumChannels-1:0] pend_q, pend_d, pend_set, pend_clr;
  logic [DataWidth-1:0]   rdata;
  logic                   unused_bits;

  assign word        = addr_i[AddressWidth-1:2];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign sel_presc   = (word == '0);
  assign sel_status  = (word == WordWidth'(1));
  assign unused_bits = ^{addr_i[1:0], data_i};

  // Channel n occupies word indices 4+4n .. 7+4n; the last slot is reserved.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no path can infer a latch.
    sel_ctrl = '0;
    sel_cmp  = '0;
    sel_cnt  = '0;
    for (int n = 0; n < NumChannels; n++) begin
      sel_ctrl[n] = (word == WordWidth'(4 + 4 * n));
      sel_cmp[n]  = (word == WordWidth'(5 + 4 * n));
      sel_cnt[n]  = (word == WordWidth'(6 + 4 * n));
    end
  end

  // A PRESC write restarts the prescaler and suppresses that cycle's tick.
  assign tick        = (presc_cnt_q == presc_q) && !(wr && sel_presc);
  assign presc_cnt_d = ((wr && sel_presc) || tick) ? '0 : presc_cnt_q + PrescWidth'(1);
  assign pend_clr    = (wr && sel_status) ? data_i[NumChannels-1:0] : '0;
  assign pend_d      = (pend_q & ~pend_clr) | pend_set;

  always_comb begin
    pend_set = '0;
    for (int n = 0; n < NumChannels; n++) begin
      ctrl_d[n] = ctrl_q[n];
      cmp_d[n]  = cmp_q[n];
      cnt_d[n]  = cnt_q[n];
      // A bus write to CTRL or CNT wins over the tick for this channel.
      if (tick && ctrl_q[n].enable && !(wr && (sel_ctrl[n] || sel_cnt[n]))) begin
        if (cnt_q[n] == cmp_q[n]) begin
          pend_set[n] = 1'b1;
          if (ctrl_q[n].periodic) cnt_d[n] = '0;
          else                    ctrl_d[n].enable = 1'b0;
        end else begin
          cnt_d[n] = cnt_q[n] + DataWidth'(1);
        end
      end
      if (wr && sel_ctrl[n]) ctrl_d[n] = ctrl_t'(data_i[2:0]);
      if (wr && sel_cmp[n])  cmp_d[n]  = data_i;
      if (wr && sel_cnt[n])  cnt_d[n]  = data_i;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_presc)  rdata = DataWidth'(presc_q);
    if (sel_status) rdata = DataWidth'(pend_q);
    for (int n = 0; n < NumChannels; n++) begin
      if (sel_ctrl[n]) rdata = DataWidth'(ctrl_q[n]);
      if (sel_cmp[n])  rdata = cmp_q[n];
      if (sel_cnt[n])  rdata = cnt_q[n];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
      pend_q      <= '0;
      data_o      <= '0;
      rvalid_o    <= 1'b0;
      // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset like any other state.
      for (int n = 0; n < NumChannels; n++) begin
        ctrl_q[n] <= '0;
        cmp_q[n]  <= '0;
        cnt_q[n]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
      presc_cnt_q <= presc_cnt_d;
      pend_q      <= pend_d;
      rvalid_o    <= req_i;
      if (wr && sel_presc) presc_q <= data_i[PrescWidth-1:0];
      if (rd)              data_o  <= rdata;
      for (int n = 0; n < NumChannels; n++) begin
        ctrl_q[n] <= ctrl_d[n];
        cmp_q[n]  <= cmp_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
    end
  end

  always_comb begin
    irq_o = '0;
    for (int n = 0; n < NumChannels; n++) irq_o[n] = pend_q[n] & ctrl_q[n].irq_en;
  end

  assign halt_o = |irq_o;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: register table, directed timing sequences
// and randomized bus traffic compared every cycle against a rule-level model.
module tb_multi_timer;
  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req = 1'b0;
  logic           we = 1'b0;
  logic [31:0]    addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic           rvalid;
  logic [NCH-1:0] irq;
  logic           halt;

  int total = 0;
  int bad = 0;

  multi_timer #(
    .DataWidth(32), .AddressWidth(32), .NumChannels(NCH), .PrescWidth(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(rdata), .rvalid_o(rvalid), .irq_o(irq), .halt_o(halt)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain per-register variables.
  bit [7:0]     m_presc, m_pcnt;
  bit           m_en [NCH];
  bit           m_per [NCH];
  bit           m_ie [NCH];
  bit [31:0]    m_cmp [NCH];
  bit [31:0]    m_cnt [NCH];
  bit [NCH-1:0] m_pend;
  bit [31:0]    m_data;
  bit           m_rvalid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [NCH-1:0] model_irq();
    bit [NCH-1:0] r = '0;
    for (int ch = 0; ch < NCH; ch++) r[ch] = m_pend[ch] & m_ie[ch];
    return r;
  endfunction

  function automatic bit [31:0] model_read(input int unsigned w);
    int unsigned ch, r;
    if (w == 0) return 32'(m_presc);
    if (w == 1) return 32'(m_pend);
    if (w < 4 || w >= 4 + 4 * NCH) return 0;
    ch = (w - 4) / 4;
    r  = (w - 4) % 4;
    case (r)
      0: return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
      1: return m_cmp[ch];
      2: return m_cnt[ch];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_pcnt = 0; m_pend = 0; m_data = 0; m_rvalid = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_en[ch] = 0; m_per[ch] = 0; m_ie[ch] = 0; m_cmp[ch] = 0; m_cnt[ch] = 0;
    end
  endtask

  // One clock edge of the register-level rules, given the bus access presented on it.
  task automatic model_step(input bit rq, input bit w, input bit [31:0] a, input bit [31:0] d);
    int unsigned wd = a >> 2;
    bit wp, tk;
    bit [NCH-1:0] setb, clrb;
    wp = rq && w && (wd == 0);
    tk = !wp && (m_pcnt == m_presc);
    m_rvalid = rq;
    if (rq && !w) m_data = model_read(wd);
    m_pcnt = (wp || tk) ? 8'd0 : m_pcnt + 8'd1;
    setb = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      bit busy;
      busy = rq && w && (wd == 4 + 4 * ch || wd == 6 + 4 * ch);
      if (tk && m_en[ch] && !busy) begin
        if (m_cnt[ch] == m_cmp[ch]) begin
          setb[ch] = 1;
          if (m_per[ch]) m_cnt[ch] = 0;
          else m_en[ch] = 0;
        end else begin
          m_cnt[ch] = m_cnt[ch] + 1;
        end
      end
    end
    clrb = (rq && w && wd == 1) ? d[NCH-1:0] : '0;
    if (rq && w) begin
      if (wp) m_presc = d[7:0];
      if (wd >= 4 && wd < 4 + 4 * NCH) begin
        case ((wd - 4) % 4)
          0: begin
            m_en[(wd - 4) / 4]  = d[0];
            m_per[(wd - 4) / 4] = d[1];
            m_ie[(wd - 4) / 4]  = d[2];
          end
          1: m_cmp[(wd - 4) / 4] = d;
          2: m_cnt[(wd - 4) / 4] = d;
          default: ;
        endcase
      end
    end
    m_pend = (m_pend & ~clrb) | setb;
  endtask

  task automatic do_cycle(input bit rq, input bit w, input bit [31:0] a, input bit [31:0] d);
    req = rq; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(rq, w, a, d);
    #1;
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("data_o", rdata, m_data);
    check("irq_o", 32'(irq), 32'(model_irq()));
    check("halt_o", 32'(halt), 32'(|model_irq()));
    req = 0; we = 0;
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d);
    do_cycle(1, 1, a, d);
  endtask

  task automatic rd(input bit [31:0] a);
    do_cycle(1, 0, a, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0);
  endtask

  function automatic bit [31:0] a_ctrl(input int ch); return 32'(16 + 16 * ch); endfunction
  function automatic bit [31:0] a_cmp(input int ch);  return 32'(20 + 16 * ch); endfunction
  function automatic bit [31:0] a_cnt(input int ch);  return 32'(24 + 16 * ch); endfunction

  task automatic apply_reset();
    req = 0; we = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_irq", 32'(irq), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_data", rdata, 0);
    check("rst_rvalid", 32'(rvalid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs = '{
      '{1, 32'h00, 32'h1FF, 0},          '{0, 32'h00, 0, 32'hFF},
      '{1, 32'h14, 32'h1234, 0},         '{0, 32'h14, 0, 32'h1234},
      '{1, 32'h30, 32'h7, 0},            '{0, 32'h30, 0, 0},
      '{0, 32'h08, 0, 0},                '{0, 32'h1C, 0, 0},
      '{1, 32'h20, 32'hFFFF_FFFA, 0},    '{0, 32'h20, 0, 32'h2},
      '{1, 32'h18, 32'hDEAD, 0},         '{0, 32'h18, 0, 32'hDEAD},
      '{0, 32'h38, 0, 0},                '{0, 32'h05, 0, 0},
      '{0, 32'h10, 0, 0}
    };

    #2;
    apply_reset();

    // Register map: masking, reserved and out-of-range indices.
    foreach (vecs[i]) begin
      do_cycle(1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check("tbl_rvalid", 32'(rvalid), 1);
      if (!vecs[i].we) check("tbl_rdata", rdata, vecs[i].exp);
    end

    // One-shot channel 0, match four cycles after enabling.
    apply_reset();
    wr(0, 0); wr(a_cmp(0), 3); wr(a_ctrl(0), 32'b101);
    idle(3);
    check("oneshot_early", 32'(irq), 0);
    idle(1);
    check("oneshot_irq", 32'(irq), 1);
    check("oneshot_halt", 32'(halt), 1);
    rd(a_ctrl(0)); check("oneshot_ctrl", rdata, 32'b100);
    rd(a_cnt(0));  check("oneshot_cnt", rdata, 3);

    // Periodic channel 1 with prescaler 2.
    apply_reset();
    wr(0, 2); wr(a_cmp(1), 1); wr(a_ctrl(1), 32'b111);
    rd(a_cnt(1)); check("per_cnt0", rdata, 0);
    rd(a_cnt(1)); check("per_cnt1", rdata, 1);
    idle(1); check("per_early", 32'(irq), 0);
    idle(1); check("per_irq", 32'(irq), 2);
    check("per_halt", 32'(halt), 1);
    wr(4, 2); check("per_w1c", 32'(irq), 0);
    rd(a_cnt(1)); check("per_cnt2", rdata, 0);
    idle(3); check("per_gap", 32'(irq), 0);
    idle(1); check("per_again", 32'(irq), 2);

    // Pending set collides with a write-1-to-clear.
    apply_reset();
    wr(0, 0); wr(a_cmp(0), 2); wr(a_ctrl(0), 32'b111);
    idle(2);
    wr(4, 1);
    check("w1c_race_irq", 32'(irq), 1);
    check("w1c_race_halt", 32'(halt), 1);
    wr(4, 1);
    check("w1c_clear", 32'(irq), 0);

    // Counter wrap, then CNT write racing a tick.
    apply_reset();
    wr(0, 0); wr(a_cmp(0), 5); wr(a_cnt(0), 32'hFFFF_FFFF); wr(a_ctrl(0), 1);
    idle(1);
    rd(a_cnt(0)); check("wrap_cnt", rdata, 0);
    idle(5);
    rd(4);         check("wrap_pend", rdata, 1);
    rd(a_cnt(0));  check("wrap_hold", rdata, 5);
    rd(a_ctrl(0)); check("wrap_ctrl", rdata, 0);
    wr(a_cnt(0), 100); wr(a_ctrl(0), 1);
    idle(1);
    wr(a_cnt(0), 32'h55);
    rd(a_cnt(0)); check("cnt_write_wins", rdata, 32'h55);

    // Asynchronous reset in the middle of a count.
    apply_reset();
    wr(0, 0); wr(a_cmp(1), 0); wr(a_cmp(0), 1000);
    wr(a_ctrl(0), 32'b111); wr(a_ctrl(1), 32'b101);
    idle(1);
    check("pre_rst_irq", 32'(irq), 2);
    rd(a_cmp(0)); check("pre_rst_data", rdata, 1000);
    #2;
    apply_reset();
    idle(200);
    check("post_rst_irq", 32'(irq), 0);
    rd(a_cnt(0)); check("post_rst_cnt", rdata, 0);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned r, t, w;
      bit [31:0] d;
      r = $urandom_range(0, 15);
      if (r < 6) begin
        idle(1);
      end else if (r < 10) begin
        w = $urandom_range(0, 15);
        rd(32'(w * 4 + $urandom_range(0, 3)));
      end else begin
        t = $urandom_range(0, 6);
        case (t)
          0: wr(0, 32'($urandom_range(0, 3)));
          1: wr(4, $urandom);
          2, 3: wr(a_ctrl($urandom_range(0, NCH - 1)), $urandom);
          4: wr(a_cmp($urandom_range(0, NCH - 1)), 32'($urandom_range(0, 6)));
          5: begin
            if ($urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 6));
            else d = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            wr(a_cnt($urandom_range(0, NCH - 1)), d);
          end
          default: begin
            w = $urandom_range(0, 15);
            d = $urandom;
            if (w == 0) d = d & 32'h3;
            wr(32'(w * 4), d);
          end
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
